can_edge_stamper: RTL and testbench



---
 rtl/can_edge_stamper.sv | 119 +++++++++++
 tb/tb_can_edge_stamper.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/can_edge_stamper.sv
// CAN RX edge timestamper: filters RX, stamps filtered edges with coarse+fine time, feeds a 34-bit FIFO.
// Optional drop-report words are enabled with `define CAN_STAMP_DROP_MARK_EN.
module can_edge_stamper #(
    parameter int CW   = 24,  // CW + FW must equal 32
    parameter int FW   = 8,
    parameter int FILT = 4,
    parameter int DCW  = 16
) (
    input  logic           CLK,
    input  logic           nRST,
    input  logic           RX_IN,
    input  logic           EN,
    input  logic [FW-1:0]  FINE,
    input  logic           FULL,
    output logic [33:0]    D,
    output logic           WR,
    output logic           RX_FILT,
    output logic [DCW-1:0] DROP_CNT
);
    localparam logic [3:0]  FILT_LAST = 4'(FILT - 1);
    localparam logic [33:0] MARK_WORD = {2'b01, 32'd0};

    logic          sync1, sync2, rx_prev;
    logic [3:0]    filt_cnt;
    logic [CW-1:0] coarse;
    logic [33:0]   q [2];
    logic [1:0]    q_cnt;

    logic          edge_det, wrap, rpt, pop;
    logic [33:0]   cand [4];
    logic [2:0]    n_cand, keep, n_drop;
    logic [DCW:0]  drop_sum;

    assign edge_det = EN && (RX_FILT != rx_prev);
    assign wrap     = EN && (coarse == '1);

`ifdef CAN_STAMP_DROP_MARK_EN
    logic owe;
    // Report only into an idle path so it never competes with real words.
    assign rpt = owe && (q_cnt == 2'd0) && !FULL && !edge_det && !wrap;
`else
    assign rpt = 1'b0;
`endif

    // Queued words followed by this cycle's new words, in issue order; the head may pop immediately.
    always_comb begin
        cand    = '{default: '0};
        cand[0] = q[0];
        cand[1] = q[1];
        n_cand  = {1'b0, q_cnt};
        if (edge_det) begin
            cand[n_cand[1:0]] = {RX_FILT, 1'b0, coarse, FINE};
            n_cand = n_cand + 3'd1;
        end
        if (wrap) begin
            cand[n_cand[1:0]] = MARK_WORD;
            n_cand = n_cand + 3'd1;
        end
        if (rpt) begin
            cand[0] = {2'b11, {(32-DCW){1'b0}}, DROP_CNT};
            n_cand  = 3'd1;
        end
        pop      = (n_cand != 3'd0) && !FULL;
        keep     = n_cand - {2'b00, pop};
        n_drop   = (keep > 3'd2) ? keep - 3'd2 : 3'd0;
        drop_sum = {1'b0, DROP_CNT} + (DCW+1)'(n_drop);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            RX_FILT  <= 1'b1;
            rx_prev  <= 1'b1;
            filt_cnt <= '0;
            coarse   <= '0;
        end else begin
            sync1   <= RX_IN;
            sync2   <= sync1;
            rx_prev <= RX_FILT;
            if (sync2 == RX_FILT) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                RX_FILT  <= ~RX_FILT;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 4'd1;
            end
            if (EN) coarse <= coarse + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            D        <= '0;
            WR       <= 1'b0;
            q[0]     <= '0;
            q[1]     <= '0;
            q_cnt    <= '0;
            DROP_CNT <= '0;
        end else begin
            WR <= pop;
            if (pop) D <= cand[0];
            q[0]  <= pop ? cand[1] : cand[0];
            q[1]  <= pop ? cand[2] : cand[1];
            q_cnt <= (keep > 3'd2) ? 2'd2 : keep[1:0];
            if (n_drop != 3'd0) DROP_CNT <= drop_sum[DCW] ? '1 : drop_sum[DCW-1:0];
        end
    end

`ifdef CAN_STAMP_DROP_MARK_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                owe <= 1'b0;
        else if (n_drop != 3'd0)  owe <= 1'b1;
        else if (rpt)             owe <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_can_edge_stamper.sv
// Scoreboard bench for can_edge_stamper with CW=8/FW=24/FILT=4/DCW=4 so rollover and saturation are short.
module tb_can_edge_stamper;
    localparam int CW = 8, FW = 24, FILT = 4, DCW = 4;
    localparam logic [33:0] MARK = 34'h1_0000_0000;

    logic           CLK = 1'b0, nRST = 1'b1, RX_IN = 1'b1, EN = 1'b1, FULL = 1'b0;
    logic [FW-1:0]  FINE = '0;
    logic [33:0]    D;
    logic           WR, RX_FILT;
    logic [DCW-1:0] DROP_CNT;

    can_edge_stamper #(.CW(CW), .FW(FW), .FILT(FILT), .DCW(DCW)) dut (
        .CLK(CLK), .nRST(nRST), .RX_IN(RX_IN), .EN(EN), .FINE(FINE), .FULL(FULL),
        .D(D), .WR(WR), .RX_FILT(RX_FILT), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_pass = 0;
    logic [33:0] exp_q [$];
    logic [CW-1:0] exp_coarse;
    int cyc;
    logic full_edge = 1'b0;

    task automatic chk(input string name, input logic [33:0] got, input logic [33:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference coarse time: EN-qualified cycle count since reset release.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            exp_coarse <= '0;
            cyc        <= 0;
        end else begin
            if (EN) exp_coarse <= exp_coarse + 1'b1;
            cyc <= cyc + 1;
        end
    end

    always @(posedge CLK) full_edge <= FULL;

    always @(negedge CLK) begin
        if (nRST && WR) begin
            chk("wr_while_full", 34'(full_edge), 34'd0);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_wr: got D=%h expected no write", D);
            end else begin
                chk("fifo_word", D, exp_q.pop_front());
            end
        end
    end

    // Drive one RX transition; returns in the edge-detect cycle.
    task automatic rx_edge(input logic lvl, input logic [FW-1:0] f, input bit push);
        logic old;
        @(negedge CLK);
        old   = RX_FILT;
        RX_IN = lvl;
        FINE  = f;
        repeat (FILT + 1) @(negedge CLK);
        chk("filt_hold", 34'(RX_FILT), 34'(old));
        @(negedge CLK);
        chk("filt_latency", 34'(RX_FILT), 34'(lvl));
        if (push) exp_q.push_back({lvl, 1'b0, exp_coarse, f});
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0; FULL = 1'b0; EN = 1'b1; RX_IN = 1'b1;
        repeat (2) @(negedge CLK);
        exp_q.delete();
        nRST = 1'b1;
    endtask

    initial begin
        bit seen_low;
        // Reset state and first marker timing
        #1 nRST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_wr", 34'(WR), 34'd0);
        chk("rst_d", D, 34'd0);
        chk("rst_filt", 34'(RX_FILT), 34'd1);
        chk("rst_drop", 34'(DROP_CNT), 34'd0);
        nRST = 1'b1;

        // 3-cycle glitch must be filtered out
        @(negedge CLK); RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        seen_low = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (!RX_FILT) seen_low = 1'b1;
        end
        chk("glitch_filtered", 34'(seen_low), 34'd0);

        rx_edge(1'b0, 24'h0000A5, 1'b1);
        @(negedge CLK);
        chk("ev_wr_e1", 34'(WR), 34'd1);
        chk("ev_fine", 34'(D[7:0]), 34'h0A5);
        chk("ev_flags", 34'(D[33:32]), 34'd0);
        @(negedge CLK);
        chk("ev_wr_one_cycle", 34'(WR), 34'd0);
        rx_edge(1'b1, 24'h00005A, 1'b1);

        while (exp_coarse != 8'hFF) @(negedge CLK);
        exp_q.push_back(MARK);
        @(negedge CLK);
        chk("first_mark_wr", 34'(WR), 34'd1);
        chk("first_mark_cycle", 34'(cyc), 34'd256);

        // Back-pressure: 4 edges while FULL, 2 kept, 2 dropped
        do_reset();
        @(negedge CLK); FULL = 1'b1;
        rx_edge(1'b0, 24'h000011, 1'b1);
        rx_edge(1'b1, 24'h000022, 1'b1);
        rx_edge(1'b0, 24'h000033, 1'b0);
        rx_edge(1'b1, 24'h000044, 1'b0);
        @(negedge CLK);
        chk("bp_drop_cnt", 34'(DROP_CNT), 34'd2);
        chk("bp_no_wr", 34'(WR), 34'd0);
`ifdef CAN_STAMP_DROP_MARK_EN
        exp_q.push_back({2'b11, 28'd0, 4'd2});
`endif
        FULL = 1'b0;
        @(negedge CLK); chk("bp_wr1", 34'(WR), 34'd1);
        @(negedge CLK); chk("bp_wr2", 34'(WR), 34'd1);
`ifdef CAN_STAMP_DROP_MARK_EN
        @(negedge CLK); chk("bp_report_wr", 34'(WR), 34'd1);
`endif
        repeat (20) @(negedge CLK);
        chk("bp_drained", 34'(exp_q.size()), 34'd0);

        // Saturation: 22 edges while FULL -> 20 drops, count pins at 4'hF
        do_reset();
        @(negedge CLK); FULL = 1'b1;
        for (int i = 0; i < 22; i++) begin
            rx_edge(i[0], FW'(i + 1), i < 2);
            if (i == 16) begin
                @(negedge CLK);
                chk("sat_reach", 34'(DROP_CNT), 34'hF);
            end
        end
        @(negedge CLK);
        chk("sat_hold", 34'(DROP_CNT), 34'hF);
        FULL = 1'b0;
        @(negedge CLK);
        chk("drain_wr", 34'(WR), 34'd1);
        #2 nRST = 1'b0;
        #1;
        chk("arst_wr", 34'(WR), 34'd0);
        chk("arst_d", D, 34'd0);
        chk("arst_drop", 34'(DROP_CNT), 34'd0);
        chk("arst_filt", 34'(RX_FILT), 34'd1);
        exp_q.delete();
        @(negedge CLK); nRST = 1'b1;
        repeat (10) @(negedge CLK);

        // Rollover: edge in the coarse==FF cycle, then EN hold
        do_reset();
        while (exp_coarse != 8'hF8) @(negedge CLK);
        rx_edge(1'b0, 24'hC0FFEE, 1'b0);
        exp_q.push_back({2'b00, 8'hFF, 24'hC0FFEE});
        exp_q.push_back(MARK);
        @(negedge CLK); chk("roll_wr1", 34'(WR), 34'd1);
        @(negedge CLK); chk("roll_wr2", 34'(WR), 34'd1);
        @(negedge CLK); chk("roll_wr_end", 34'(WR), 34'd0);
        EN = 1'b0;
        rx_edge(1'b1, 24'h000001, 1'b0);
        repeat (5) @(negedge CLK);
        EN = 1'b1;
        rx_edge(1'b0, 24'h000077, 1'b1);
        @(negedge CLK); chk("en_resume_wr", 34'(WR), 34'd1);
        repeat (5) @(negedge CLK);
        chk("final_drained", 34'(exp_q.size()), 34'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
